// File: rtl/frame_deserializer_if.sv
// Consumer-side byte handshake of the serial receiver: data/valid forward, ack back.
interface frame_deserializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ack
    );
endinterface

// File: rtl/frame_deserializer.sv
// Serial byte link receiver: hunts for the start marker, shifts in DATA_W bits
// LSB first, checks the end marker and hands the byte out on a valid/ack handshake.
module frame_deserializer #(
    parameter int unsigned DATA_W = 8,
    parameter logic [4:0]  SOF    = 5'b10001,
    parameter logic [4:0]  EOF    = 5'b01110
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serin,
    frame_deserializer_if.master rx,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    // Counter must reach DATA_W-1 in DATA and 4 in TRAILER.
    localparam int unsigned CNT_W = (DATA_W > 5) ? $clog2(DATA_W) : 3;
    localparam int unsigned MRK_W = 5;

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] DATA    = 2'd1;
    localparam logic [1:0] TRAILER = 2'd2;

    logic [1:0]        state,     state_n;
    logic [MRK_W-1:0]  win,       win_n;
    logic [CNT_W-1:0]  cnt,       cnt_n;
    logic [DATA_W-1:0] shreg,     shreg_n;
    logic [DATA_W-1:0] data_q,    data_n;
    logic              valid_q,   valid_n;
    logic              err_n;
    logic              ovr_n;
    logic              busy_n;
    logic [MRK_W-1:0]  win_shift;

    assign rx.rx_data  = data_q;
    assign rx.rx_valid = valid_q;

    // State and output registers; reset discards any partial frame and pending byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= HUNT;
            win       <= '0;
            cnt       <= '0;
            shreg     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            win       <= win_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            frame_err <= err_n;
            overrun   <= ovr_n;
            busy      <= busy_n;
        end
    end

    // Next-state, framing and handshake logic.
    always_comb begin
        state_n   = state;
        win_n     = win;
        cnt_n     = cnt;
        shreg_n   = shreg;
        data_n    = data_q;
        valid_n   = valid_q;
        err_n     = 1'b0;
        ovr_n     = 1'b0;
        win_shift = {win[MRK_W-2:0], serin};

        if (valid_q && rx.rx_ack) begin
            valid_n = 1'b0;
        end

        case (state)
            HUNT: begin
                if (win_shift == SOF) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    win_n   = '0;
                end else begin
                    win_n   = win_shift;
                end
            end
            DATA: begin
                shreg_n[cnt] = serin;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_n = TRAILER;
                    cnt_n   = '0;
                    win_n   = '0;
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
            TRAILER: begin
                if (cnt == CNT_W'(MRK_W - 1)) begin
                    // Window is cleared on exit so trailer bits can't seed a false start.
                    state_n = HUNT;
                    cnt_n   = '0;
                    win_n   = '0;
                    if (win_shift == EOF) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        ovr_n   = valid_q && !rx.rx_ack;
                    end else begin
                        err_n   = 1'b1;
                    end
                end else begin
                    win_n   = win_shift;
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = HUNT;
                cnt_n   = '0;
                win_n   = '0;
            end
        endcase

        busy_n = (state_n == DATA) || (state_n == TRAILER);
    end
endmodule
